pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 16, program counter width in bits.
REQ-002 Parameter RAS_DEPTH, default 8, number of return-address-stack entries (power of two).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 data_hazard  in  1  load-use stall request from hazard detection.
REQ-006 PC_hazard  in  1  control-flow stall request from hazard detection.
REQ-007 pop_haz  in  1  stack-pop stall request from hazard detection.
REQ-008 branch_req  in  1  taken branch resolved this cycle.
REQ-009 jreg_req  in  1  register-indirect jump this cycle.
REQ-010 call_req  in  1  call this cycle.
REQ-011 ret_req  in  1  return this cycle.
REQ-012 target  in  PC_W  redirect address for branch/jreg/call; ignored for ret.
REQ-013 pc  out  PC_W  current fetch address.
REQ-014 instr_valid  out  1  fetch at pc is valid; low inserts a bubble into IF/ID.
REQ-015 PC_update  out  1  one-cycle pulse: redirect committed to pc.
REQ-016 ras_overflow  out  1  sticky: push made while stack full.
REQ-017 ras_underflow  out  1  sticky: pop made while stack empty.

Function
REQ-018 The block SHALL implement FSM states RUN and REDIRECT.
REQ-019 stall = data_hazard | PC_hazard | pop_haz.
REQ-020 In RUN with no request and stall=0, the block SHALL set pc <= pc+1 and drive instr_valid=1.
REQ-021 In RUN with no request and stall=1, the block SHALL hold pc and drive instr_valid=0.
REQ-022 In RUN, any request SHALL be accepted regardless of stall, move the FSM to REDIRECT, hold pc, and drive instr_valid=0.
REQ-023 When multiple requests are asserted together, priority SHALL be branch > jreg > call > ret; lower-priority requests that cycle SHALL be discarded.
REQ-024 On acceptance, the block SHALL latch next_pc = target for branch/jreg/call, and = top of stack for ret.
REQ-025 An accepted call SHALL push pc+1 (modulo 2^PC_W) onto the stack in the acceptance cycle.
REQ-026 An accepted ret SHALL pop the stack in the acceptance cycle.
REQ-027 In REDIRECT, the block SHALL load pc <= next_pc, pulse PC_update=1 for exactly that cycle, drive instr_valid=0, and return to RUN.
REQ-028 Requests arriving in REDIRECT SHALL be ignored.
REQ-029 Redirect latency SHALL be 2 cycles from request to the first instr_valid=1 at the new pc, given stall=0.
REQ-030 pc increment SHALL wrap from 2^PC_W-1 to 0.
REQ-031 The stack SHALL be circular. A push when full (count=RAS_DEPTH) SHALL overwrite the oldest entry, keep count=RAS_DEPTH, and set ras_overflow.
REQ-032 A pop when empty SHALL use next_pc = pc+1, leave count=0, and set ras_underflow.
REQ-033 ras_overflow and ras_underflow SHALL stay set until reset.

Reset
REQ-034 On rst, the block SHALL set pc=0, FSM=RUN, PC_update=0, instr_valid=0, stack count=0, and stack pointer=0, and clear ras_overflow and ras_underflow.
REQ-035 rst SHALL take priority over all inputs, including a redirect in progress; next_pc is discarded.
REQ-036 In the first cycle after rst deasserts, instr_valid SHALL follow REQ-020/021.

Structure
REQ-037 The PC_W/RAS_DEPTH defaults and the FSM state encoding SHALL live in the shared cpu package.
REQ-038 The return-address stack SHALL be a sub-module, ras_stack (push, pop, top, full, empty, count).

Verification
REQ-039 Reset, then 5 cycles with stall=0 -> pc sequence 0,1,2,3,4; instr_valid=1 after the first cycle.
REQ-040 pc=0x0010, data_hazard=1 for 3 cycles -> pc holds 0x0010 and instr_valid=0 for 3 cycles, then 0x0011.
REQ-041 pc=0x0020, branch_req with target=0x0100 -> REDIRECT; next cycle pc=0x0100 with PC_update=1; following cycle instr_valid=1.
REQ-042 call at pc=0x0040 (target 0x0200), then ret at pc=0x0205 -> pc returns to 0x0041; stack count 1 then 0.
REQ-043 9 calls with RAS_DEPTH=8 -> ras_overflow=1 and count=8; 9 rets -> the first 8 return in LIFO order and the 9th sets ras_underflow with pc=pc+1.
REQ-044 branch_req and ret_req in the same cycle (target=0x0300) -> pc=0x0300 with the stack unpopped; rst asserted during REDIRECT -> pc=0 and PC_update=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared cpu package: fetch-sequencer widths, FSM encoding and request arbitration.
package pc_sequencer_pkg;

  localparam int PC_W_DEF      = 16;
  localparam int RAS_DEPTH_DEF = 8;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } seq_state_e;

  typedef enum logic [2:0] {
    REQ_NONE   = 3'd0,
    REQ_BRANCH = 3'd1,
    REQ_JREG   = 3'd2,
    REQ_CALL   = 3'd3,
    REQ_RET    = 3'd4
  } req_e;

  // Fixed priority: branch > jreg > call > ret; losers are dropped.
  function automatic req_e pick_req(input logic b, input logic j, input logic c, input logic r);
    if (b)      return REQ_BRANCH;
    else if (j) return REQ_JREG;
    else if (c) return REQ_CALL;
    else if (r) return REQ_RET;
    else        return REQ_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] sp_q;
  logic [AW-1:0] top_idx;
  logic [CW-1:0] count_q;

  // sp_q is the next free slot; when full it also points at the oldest entry.
  assign top_idx = sp_q - AW'(1);
  assign top     = mem_q[top_idx];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[sp_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q    <= '0;
      count_q <= '0;
    end else if (push) begin
      sp_q <= sp_q + AW'(1);
      if (!full) count_q <= count_q + CW'(1);
    end else if (pop && !empty) begin
      sp_q    <= sp_q - AW'(1);
      count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential fetch with stalls, two-step redirects, and a return-address stack.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_hazard,
  input  logic                         PC_hazard,
  input  logic                         pop_haz,
  input  logic                         branch_req,
  input  logic                         jreg_req,
  input  logic                         call_req,
  input  logic                         ret_req,
  input  logic [PC_W-1:0]              target,
  output logic [PC_W-1:0]              pc,
  output logic                         instr_valid,
  output logic                         PC_update,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output seq_state_e                   dbg_state,
  output logic [$clog2(RAS_DEPTH):0]   dbg_ras_count
);

  seq_state_e      state_q;
  logic [PC_W-1:0] pc_q, next_pc_q, next_pc_d, pc_inc, ras_top;
  logic            instr_valid_q, pc_update_q, ovf_q, unf_q;
  logic            stall, in_run, do_push, do_pop, ras_full, ras_empty;
  req_e            req_sel;

  assign stall   = data_hazard | PC_hazard | pop_haz;
  assign req_sel = pick_req(branch_req, jreg_req, call_req, ret_req);
  assign in_run  = (state_q == ST_RUN);
  assign do_push = in_run && (req_sel == REQ_CALL);
  assign do_pop  = in_run && (req_sel == REQ_RET);
  assign pc_inc  = pc_q + PC_W'(1);

  always_comb begin
    next_pc_d = target;
    if (req_sel == REQ_RET) next_pc_d = ras_empty ? pc_inc : ras_top;
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .full      (ras_full),
    .empty     (ras_empty),
    .count     (dbg_ras_count)
  );

  // Requests are accepted even while stalled; REDIRECT always commits next_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      pc_q          <= '0;
      next_pc_q     <= '0;
      instr_valid_q <= 1'b0;
      pc_update_q   <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
    end else begin
      instr_valid_q <= 1'b0;
      pc_update_q   <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (req_sel != REQ_NONE) begin
            state_q   <= ST_REDIRECT;
            next_pc_q <= next_pc_d;
            if (do_push && ras_full) ovf_q <= 1'b1;
            if (do_pop && ras_empty) unf_q <= 1'b1;
          end else if (!stall) begin
            pc_q          <= pc_inc;
            instr_valid_q <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          pc_q        <= next_pc_q;
          pc_update_q <= 1'b1;
          state_q     <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign pc            = pc_q;
  assign instr_valid   = instr_valid_q;
  assign PC_update     = pc_update_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of per-cycle vectors plus hand-built call/ret stack sequences.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk, rst;
  logic        data_hazard, PC_hazard, pop_haz;
  logic        branch_req, jreg_req, call_req, ret_req;
  logic [15:0] target, pc;
  logic        instr_valid, PC_update, ras_overflow, ras_underflow;
  seq_state_e  dbg_state;
  logic [3:0]  dbg_ras_count;

  int errors = 0;
  int checks = 0;

  logic [23:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    string       name;
    logic        r;
    logic [2:0]  haz;
    logic [3:0]  req;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic        e_iv, e_pu, e_ov, e_un;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  pc_sequencer #(.PC_W(16), .RAS_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_hazard   (data_hazard),
    .PC_hazard     (PC_hazard),
    .pop_haz       (pop_haz),
    .branch_req    (branch_req),
    .jreg_req      (jreg_req),
    .call_req      (call_req),
    .ret_req       (ret_req),
    .target        (target),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .PC_update     (PC_update),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .dbg_state     (dbg_state),
    .dbg_ras_count (dbg_ras_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string n, input logic r, input logic [2:0] h, input logic [3:0] q,
                     input logic [15:0] t, input logic [15:0] p, input logic v, input logic u,
                     input logic o, input logic f, input logic [3:0] c);
    vec_t x;
    x.name = n; x.r = r; x.haz = h; x.req = q; x.tgt = t;
    x.e_pc = p; x.e_iv = v; x.e_pu = u; x.e_ov = o; x.e_un = f; x.e_cnt = c;
    vecs.push_back(x);
  endtask

  // Scoreboard compare of the outputs produced by the last edge
  task automatic check_out();
    logic [23:0] got, exp;
    string       n;
    got = {pc, instr_valid, PC_update, ras_overflow, ras_underflow, dbg_ras_count};
    exp = exp_q.pop_front();
    n   = name_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h iv=%b pu=%b ovf=%b unf=%b cnt=%0d, want pc=%h iv=%b pu=%b ovf=%b unf=%b cnt=%0d",
               n, got[23:8], got[7], got[6], got[5], got[4], got[3:0],
               exp[23:8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // Driver: apply one cycle of inputs at the falling edge, compare at the next falling edge
  task automatic step(input string n, input logic r, input logic [2:0] h, input logic [3:0] q,
                      input logic [15:0] t, input logic [15:0] p, input logic v, input logic u,
                      input logic o, input logic f, input logic [3:0] c);
    rst = r;
    {data_hazard, PC_hazard, pop_haz} = h;
    {branch_req, jreg_req, call_req, ret_req} = q;
    target = t;
    exp_q.push_back({p, v, u, o, f, c});
    name_q.push_back(n);
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    logic [15:0] pushed [9];
    logic [15:0] cur, tgt, nxt;
    logic [3:0]  cnt;
    logic        ov, un;

    rst = 1'b1;
    {data_hazard, PC_hazard, pop_haz} = '0;
    {branch_req, jreg_req, call_req, ret_req} = '0;
    target = '0;

    //  name               rst haz     req      tgt       pc       iv pu ov un cnt
    add("reset",            1, 3'b000, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add("seq1",             0, 3'b000, 4'b0000, 16'h0000, 16'h0001, 1, 0, 0, 0, 0);
    add("seq2",             0, 3'b000, 4'b0000, 16'h0000, 16'h0002, 1, 0, 0, 0, 0);
    add("seq3",             0, 3'b000, 4'b0000, 16'h0000, 16'h0003, 1, 0, 0, 0, 0);
    add("seq4",             0, 3'b000, 4'b0000, 16'h0000, 16'h0004, 1, 0, 0, 0, 0);
    add("stall_pc_haz",     0, 3'b010, 4'b0000, 16'h0000, 16'h0004, 0, 0, 0, 0, 0);
    add("stall_pop_haz",    0, 3'b001, 4'b0000, 16'h0000, 16'h0004, 0, 0, 0, 0, 0);
    add("seq5",             0, 3'b000, 4'b0000, 16'h0000, 16'h0005, 1, 0, 0, 0, 0);
    add("br10_acc",         0, 3'b000, 4'b1000, 16'h0010, 16'h0005, 0, 0, 0, 0, 0);
    add("br10_load",        0, 3'b000, 4'b0000, 16'h0000, 16'h0010, 0, 1, 0, 0, 0);
    add("dhaz1",            0, 3'b100, 4'b0000, 16'h0000, 16'h0010, 0, 0, 0, 0, 0);
    add("dhaz2",            0, 3'b100, 4'b0000, 16'h0000, 16'h0010, 0, 0, 0, 0, 0);
    add("dhaz3",            0, 3'b100, 4'b0000, 16'h0000, 16'h0010, 0, 0, 0, 0, 0);
    add("dhaz_release",     0, 3'b000, 4'b0000, 16'h0000, 16'h0011, 1, 0, 0, 0, 0);
    add("br20_acc",         0, 3'b000, 4'b1000, 16'h0020, 16'h0011, 0, 0, 0, 0, 0);
    add("br20_load",        0, 3'b000, 4'b0000, 16'h0000, 16'h0020, 0, 1, 0, 0, 0);
    add("br100_stall_acc",  0, 3'b100, 4'b1000, 16'h0100, 16'h0020, 0, 0, 0, 0, 0);
    add("redir_ignore_req", 0, 3'b000, 4'b0100, 16'h0BAD, 16'h0100, 0, 1, 0, 0, 0);
    add("br100_valid",      0, 3'b000, 4'b0000, 16'h0000, 16'h0101, 1, 0, 0, 0, 0);
    add("jreg_over_call",   0, 3'b000, 4'b0110, 16'h0300, 16'h0101, 0, 0, 0, 0, 0);
    add("jreg_load",        0, 3'b000, 4'b0000, 16'h0000, 16'h0300, 0, 1, 0, 0, 0);
    add("br40_acc",         0, 3'b000, 4'b1000, 16'h0040, 16'h0300, 0, 0, 0, 0, 0);
    add("br40_load",        0, 3'b000, 4'b0000, 16'h0000, 16'h0040, 0, 1, 0, 0, 0);
    add("call_acc",         0, 3'b000, 4'b0010, 16'h0200, 16'h0040, 0, 0, 0, 0, 1);
    add("call_load",        0, 3'b000, 4'b0000, 16'h0000, 16'h0200, 0, 1, 0, 0, 1);
    add("run201",           0, 3'b000, 4'b0000, 16'h0000, 16'h0201, 1, 0, 0, 0, 1);
    add("run202",           0, 3'b000, 4'b0000, 16'h0000, 16'h0202, 1, 0, 0, 0, 1);
    add("run203",           0, 3'b000, 4'b0000, 16'h0000, 16'h0203, 1, 0, 0, 0, 1);
    add("run204",           0, 3'b000, 4'b0000, 16'h0000, 16'h0204, 1, 0, 0, 0, 1);
    add("run205",           0, 3'b000, 4'b0000, 16'h0000, 16'h0205, 1, 0, 0, 0, 1);
    add("br_ret_acc",       0, 3'b000, 4'b1001, 16'h0300, 16'h0205, 0, 0, 0, 0, 1);
    add("br_ret_load",      0, 3'b000, 4'b0000, 16'h0000, 16'h0300, 0, 1, 0, 0, 1);
    add("br205_acc",        0, 3'b000, 4'b1000, 16'h0205, 16'h0300, 0, 0, 0, 0, 1);
    add("br205_load",       0, 3'b000, 4'b0000, 16'h0000, 16'h0205, 0, 1, 0, 0, 1);
    add("ret_acc",          0, 3'b000, 4'b0001, 16'h0777, 16'h0205, 0, 0, 0, 0, 0);
    add("ret_load",         0, 3'b000, 4'b0000, 16'h0000, 16'h0041, 0, 1, 0, 0, 0);
    add("ret_run",          0, 3'b000, 4'b0000, 16'h0000, 16'h0042, 1, 0, 0, 0, 0);
    add("br500_acc",        0, 3'b000, 4'b1000, 16'h0500, 16'h0042, 0, 0, 0, 0, 0);
    add("rst_in_redirect",  1, 3'b000, 4'b1000, 16'h0500, 16'h0000, 0, 0, 0, 0, 0);
    add("post_rst_stall",   0, 3'b100, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    add("post_rst_run",     0, 3'b000, 4'b0000, 16'h0000, 16'h0001, 1, 0, 0, 0, 0);
    add("brffff_acc",       0, 3'b000, 4'b1000, 16'hFFFF, 16'h0001, 0, 0, 0, 0, 0);
    add("brffff_load",      0, 3'b000, 4'b0000, 16'h0000, 16'hFFFF, 0, 1, 0, 0, 0);
    add("pc_wrap",          0, 3'b000, 4'b0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].name, vecs[i].r, vecs[i].haz, vecs[i].req, vecs[i].tgt,
           vecs[i].e_pc, vecs[i].e_iv, vecs[i].e_pu, vecs[i].e_ov, vecs[i].e_un, vecs[i].e_cnt);

    // Nine nested calls into an 8-deep stack: the oldest return address is lost
    step("ovf_seq_rst", 1, 3'b000, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    cur = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      tgt       = 16'h1000 + 16'(i) * 16'h0100;
      pushed[i] = cur + 16'h0001;
      cnt       = (i >= 7) ? 4'd8 : 4'(i + 1);
      ov        = (i == 8);
      step($sformatf("call%0d_acc", i), 0, 3'b000, 4'b0010, tgt, cur, 0, 0, ov, 0, cnt);
      step($sformatf("call%0d_load", i), 0, 3'b000, 4'b0000, 16'h0000, tgt, 0, 1, ov, 0, cnt);
      cur = tgt;
    end

    // Nine returns: eight LIFO hits, then an underflow that falls through to pc+1
    for (int j = 0; j < 9; j++) begin
      if (j < 8) begin
        nxt = pushed[8 - j];
        cnt = 4'(7 - j);
        un  = 1'b0;
      end else begin
        nxt = cur + 16'h0001;
        cnt = 4'd0;
        un  = 1'b1;
      end
      step($sformatf("ret%0d_acc", j), 0, 3'b000, 4'b0001, 16'h0ABC, cur, 0, 0, 1, un, cnt);
      step($sformatf("ret%0d_load", j), 0, 3'b000, 4'b0000, 16'h0000, nxt, 0, 1, 1, un, cnt);
      cur = nxt;
    end

    step("sticky_flags", 0, 3'b000, 4'b0000, 16'h0000, cur + 16'h0001, 1, 0, 1, 1, 0);
    step("flags_clear_rst", 1, 3'b000, 4'b0000, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
